// File: rtl/canvas_layer_manager.sv
// rtl/canvas_layer_manager.sv - active-layer select, visibility-gated tool writes and clear sweep
// All canvas write traffic funnels through one registered write port fanned out by wr_en.
module canvas_layer_manager #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 3,
  parameter int NONE_INDEX = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            layer_toggle,
  input  logic                            clear_req,
  input  logic [NUM_LAYERS-1:0]           visible,
  input  logic                            tool_valid,
  input  logic [$clog2(WIDTH)-1:0]        tool_x,
  input  logic [$clog2(HEIGHT)-1:0]       tool_y,
  input  logic [COLOR_W-1:0]              tool_color,
  output logic [NUM_LAYERS-1:0]           wr_en,
  output logic [$clog2(WIDTH)-1:0]        wr_x,
  output logic [$clog2(HEIGHT)-1:0]       wr_y,
  output logic [COLOR_W-1:0]              wr_color,
  output logic [$clog2(NUM_LAYERS+1)-1:0] current_layer,
  output logic                            busy,
  output logic                            clear_done,
  output logic [7:0]                      dropped
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = $clog2(NUM_LAYERS + 1);
  localparam logic [XW-1:0]      X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]      Y_LAST = YW'(HEIGHT - 1);
  localparam logic [LW-1:0]      L_LAST = LW'(NUM_LAYERS);
  localparam logic [COLOR_W-1:0] NONE_C = COLOR_W'(NONE_INDEX);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;

  logic [LW-1:0]         next_layer;
  logic [NUM_LAYERS-1:0] cur_onehot;
  logic [NUM_LAYERS-1:0] next_onehot;
  logic [7:0]            dropped_inc;

  always_comb begin
    next_layer = current_layer;
    if (layer_toggle)
      next_layer = (current_layer == L_LAST) ? LW'(1) : current_layer + LW'(1);
    cur_onehot  = '0;
    next_onehot = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (current_layer == LW'(i + 1)) cur_onehot[i] = 1'b1;
      if (next_layer == LW'(i + 1))    next_onehot[i] = 1'b1;
    end
    dropped_inc = (dropped == 8'hFF) ? dropped : dropped + 8'd1;
  end

  // During CLEAR, wr_en holds the latched target and wr_x/wr_y are the sweep counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      current_layer <= LW'(1);
      wr_en         <= '0;
      wr_x          <= '0;
      wr_y          <= '0;
      wr_color      <= NONE_C;
      busy          <= 1'b0;
      clear_done    <= 1'b0;
      dropped       <= 8'd0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          current_layer <= next_layer;
          wr_en         <= '0;
          if (clear_req) begin
            state    <= CLEAR;
            wr_en    <= next_onehot;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_color <= NONE_C;
            busy     <= 1'b1;
            if (tool_valid) dropped <= dropped_inc;
          end else if (tool_valid) begin
            if (|(visible & cur_onehot)) begin
              wr_en    <= cur_onehot;
              wr_x     <= tool_x;
              wr_y     <= tool_y;
              wr_color <= tool_color;
            end else begin
              dropped <= dropped_inc;
            end
          end
        end
        CLEAR: begin
          if (tool_valid) dropped <= dropped_inc;
          if (wr_x == X_LAST && wr_y == Y_LAST) begin
            state      <= IDLE;
            wr_en      <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else if (wr_x == X_LAST) begin
            wr_x <= '0;
            wr_y <= wr_y + YW'(1);
          end else begin
            wr_x <= wr_x + XW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_layer_manager.sv
// tb/tb_canvas_layer_manager.sv - vector table, corner sequences and randomized model check
module tb_canvas_layer_manager;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       layer_toggle, clear_req, tool_valid;
  logic [2:0] visible;
  logic [1:0] tool_x;
  logic [0:0] tool_y;
  logic [2:0] tool_color;
  logic [2:0] wr_en;
  logic [1:0] wr_x;
  logic [0:0] wr_y;
  logic [2:0] wr_color;
  logic [1:0] current_layer;
  logic       busy, clear_done;
  logic [7:0] dropped;

  int total = 0;
  int bad   = 0;

  canvas_layer_manager #(.WIDTH(W), .HEIGHT(H), .NUM_LAYERS(NL), .COLOR_W(3), .NONE_INDEX(0)) dut (
    .clk(clk), .reset(reset), .layer_toggle(layer_toggle), .clear_req(clear_req),
    .visible(visible), .tool_valid(tool_valid), .tool_x(tool_x), .tool_y(tool_y),
    .tool_color(tool_color), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .current_layer(current_layer), .busy(busy), .clear_done(clear_done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tog; logic clr; logic [2:0] vis; logic tv; logic [1:0] tx; logic ty; logic [2:0] tc;
    logic [2:0] e_en; logic [1:0] e_x; logic e_y; logic [2:0] e_col;
    logic [1:0] e_layer; logic e_busy; logic e_done; logic [7:0] e_drop;
  } vec_t;

  typedef struct {
    logic [2:0] en; logic [1:0] x; logic y; logic [2:0] col; logic busy; logic done;
  } out_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic tog, input logic clr, input logic [2:0] vis, input logic tv,
                       input logic [1:0] tx, input logic ty, input logic [2:0] tc);
    layer_toggle = tog; clear_req = clr; visible = vis; tool_valid = tv;
    tool_x = tx; tool_y = ty; tool_color = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic check_write(input string tag, input logic [2:0] en, input int x, input int y,
                             input int col);
    chk({tag, "_en"}, 32'(wr_en), 32'(en));
    chk({tag, "_x"}, 32'(wr_x), 32'(x));
    chk({tag, "_y"}, 32'(wr_y), 32'(y));
    chk({tag, "_color"}, 32'(wr_color), 32'(col));
  endtask

  vec_t vt[18];
  out_t q[$];
  out_t e;
  int   m_layer, m_drop, nl;
  logic m_busy;
  logic r_tog, r_clr, r_tv, r_ty;
  logic [1:0] r_tx;
  logic [2:0] r_vis, r_tc;

  initial begin
    vt[0]  = '{1,0,3'b000,0,0,0,0, 3'b000,0,0,0, 2,0,0,0};
    vt[1]  = '{1,0,3'b000,0,0,0,0, 3'b000,0,0,0, 3,0,0,0};
    vt[2]  = '{1,0,3'b000,0,0,0,0, 3'b000,0,0,0, 1,0,0,0};
    vt[3]  = '{1,0,3'b000,0,0,0,0, 3'b000,0,0,0, 2,0,0,0};
    vt[4]  = '{0,0,3'b010,1,3,1,5, 3'b010,3,1,5, 2,0,0,0};
    vt[5]  = '{0,0,3'b000,1,3,1,5, 3'b000,0,0,0, 2,0,0,1};
    vt[6]  = '{1,0,3'b000,0,0,0,0, 3'b000,0,0,0, 3,0,0,1};
    vt[7]  = '{1,0,3'b000,0,0,0,0, 3'b000,0,0,0, 1,0,0,1};
    vt[8]  = '{0,1,3'b000,0,0,0,0, 3'b001,0,0,0, 1,1,0,1};
    vt[9]  = '{0,0,3'b111,1,1,0,7, 3'b001,1,0,0, 1,1,0,2};
    vt[10] = '{1,0,3'b111,0,0,0,0, 3'b001,2,0,0, 1,1,0,2};
    vt[11] = '{0,0,3'b111,1,2,1,6, 3'b001,3,0,0, 1,1,0,3};
    vt[12] = '{0,1,3'b111,0,0,0,0, 3'b001,0,1,0, 1,1,0,3};
    vt[13] = '{0,0,3'b111,1,0,0,4, 3'b001,1,1,0, 1,1,0,4};
    vt[14] = '{0,0,3'b111,0,0,0,0, 3'b001,2,1,0, 1,1,0,4};
    vt[15] = '{0,0,3'b111,0,0,0,0, 3'b001,3,1,0, 1,1,0,4};
    vt[16] = '{0,0,3'b111,0,0,0,0, 3'b000,0,0,0, 1,0,1,4};
    vt[17] = '{0,0,3'b111,0,0,0,0, 3'b000,0,0,0, 1,0,0,4};

    reset = 1'b1;
    layer_toggle = 0; clear_req = 0; visible = 0; tool_valid = 0;
    tool_x = 0; tool_y = 0; tool_color = 0;
    @(posedge clk);
    #1;
    chk("rst_layer", 32'(current_layer), 1);
    check_write("rst", 3'b000, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    chk("rst_dropped", 32'(dropped), 0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].tog, vt[i].clr, vt[i].vis, vt[i].tv, vt[i].tx, vt[i].ty, vt[i].tc);
      chk($sformatf("vec%0d_en", i), 32'(wr_en), 32'(vt[i].e_en));
      chk($sformatf("vec%0d_layer", i), 32'(current_layer), 32'(vt[i].e_layer));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(clear_done), 32'(vt[i].e_done));
      chk($sformatf("vec%0d_dropped", i), 32'(dropped), 32'(vt[i].e_drop));
      if (vt[i].e_en != 3'b000)
        check_write($sformatf("vec%0d", i), vt[i].e_en, vt[i].e_x, vt[i].e_y, vt[i].e_col);
    end

    // Toggle and clear together on layer 3: sweep must target layer 1.
    drive(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 3'd0);
    chk("pre_combo_layer", 32'(current_layer), 3);
    drive(1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0, 3'd0);
    chk("combo_layer", 32'(current_layer), 1);
    check_write("combo_sweep0", 3'b001, 0, 0, 0);
    for (int i = 1; i < W * H; i++) begin
      idle();
      check_write($sformatf("combo_sweep%0d", i), 3'b001, i % W, i / W, 0);
      chk("combo_busy", 32'(busy), 1);
    end
    idle();
    chk("combo_done", 32'(clear_done), 1);
    chk("combo_end_en", 32'(wr_en), 0);

    // Reset asserted asynchronously in the 4th sweep cycle.
    drive(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0, 3'd0);
    check_write("abort_sweep0", 3'b010, 0, 0, 0);
    idle(); idle(); idle();
    check_write("abort_sweep3", 3'b010, 3, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_en", 32'(wr_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_layer", 32'(current_layer), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0, 3'd0);
    check_write("restart_sweep0", 3'b001, 0, 0, 0);
    chk("restart_busy", 32'(busy), 1);
    for (int i = 1; i < W * H; i++) idle();
    check_write("restart_last", 3'b001, 3, 1, 0);
    idle();
    chk("restart_done", 32'(clear_done), 1);

    // Randomized run against a queue-based model of expected port activity.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_layer = 1; m_drop = 0; m_busy = 1'b0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      r_tog = ($urandom_range(0, 9) == 0);
      r_clr = ($urandom_range(0, 39) == 0);
      r_tv  = 1'($urandom_range(0, 1));
      r_vis = 3'($urandom);
      r_tx  = 2'($urandom);
      r_ty  = 1'($urandom);
      r_tc  = 3'($urandom);
      e = '{3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0};
      if (m_busy) begin
        if (r_tv) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        e = q.pop_front();
      end else begin
        nl = r_tog ? (m_layer % NL) + 1 : m_layer;
        if (r_clr) begin
          if (r_tv) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          for (int p = 0; p < W * H; p++)
            q.push_back('{3'(1 << (nl - 1)), 2'(p % W), 1'(p / W), 3'd0, 1'b1, 1'b0});
          q.push_back('{3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1});
          e = q.pop_front();
        end else if (r_tv) begin
          if (r_vis[m_layer - 1]) e = '{3'(1 << (m_layer - 1)), r_tx, r_ty, r_tc, 1'b0, 1'b0};
          else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        m_layer = nl;
      end
      m_busy = e.busy;
      drive(r_tog, r_clr, r_vis, r_tv, r_tx, r_ty, r_tc);
      chk($sformatf("rnd%0d_en", c), 32'(wr_en), 32'(e.en));
      chk($sformatf("rnd%0d_layer", c), 32'(current_layer), 32'(m_layer));
      chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'(e.busy));
      chk($sformatf("rnd%0d_done", c), 32'(clear_done), 32'(e.done));
      chk($sformatf("rnd%0d_dropped", c), 32'(dropped), 32'(m_drop));
      if (e.en != 3'b000) begin
        chk($sformatf("rnd%0d_x", c), 32'(wr_x), 32'(e.x));
        chk($sformatf("rnd%0d_y", c), 32'(wr_y), 32'(e.y));
        chk($sformatf("rnd%0d_color", c), 32'(wr_color), 32'(e.col));
      end
    end
    chk("dropped_saturated", 32'(dropped), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/canvas_layer_manager.md
Name: canvas_layer_manager

Overview:
- Owns all write traffic into a parametrised stack of NUM_LAYERS drawing canvases. It replaces the fixed two-canvas wiring and the separate layer selector.
- Selects the active layer and gates freehand-tool pixel writes by per-layer visibility.
- Adds a hardware "clear layer" sweep that fills the active canvas with the transparent colour index.
- Sits between the freehand tool / mouse buttons and the canvases' write ports. Read side and compositor are unchanged.

Parameters:
- WIDTH, 640: canvas width in pixels.
- HEIGHT, 480: canvas height in pixels.
- NUM_LAYERS, 4: number of canvases (>=1).
- COLOR_W, 3: colour index width.
- NONE_INDEX, 0: colour index written by clear (transparent).

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high.
- layer_toggle  in  1  single-cycle pulse; advance active layer.
- clear_req  in  1  single-cycle pulse; clear active layer.
- visible  in  NUM_LAYERS  per-layer visibility, already filtered; bit i = layer i+1.
- tool_valid  in  1  tool pixel write request this cycle.
- tool_x  in  $clog2(WIDTH)  tool pixel x.
- tool_y  in  $clog2(HEIGHT)  tool pixel y.
- tool_color  in  COLOR_W  tool pixel colour.
- wr_en  out  NUM_LAYERS  one-hot (or zero) canvas write enables.
- wr_x  out  $clog2(WIDTH)  write x.
- wr_y  out  $clog2(HEIGHT)  write y.
- wr_color  out  COLOR_W  write colour.
- current_layer  out  $clog2(NUM_LAYERS+1)  active layer, 1-based.
- busy  out  1  high while a clear sweep is in progress.
- clear_done  out  1  one-cycle pulse when a sweep completes.
- dropped  out  8  saturating count of tool writes discarded.

Behaviour:
- Reset (async, active-high), all outputs: current_layer=1, wr_en=0, wr_x=0, wr_y=0, wr_color=NONE_INDEX, busy=0, clear_done=0, dropped=0, FSM=IDLE.
- All outputs are registered.
- Layer select, IDLE only:
  - layer_toggle advances current_layer 1→2→…→NUM_LAYERS→1.
  - The new value is visible the cycle after the pulse.
  - layer_toggle while busy is ignored; it is not queued.
- Tool path, IDLE only:
  - tool_valid with visible[current_layer-1]=1 → next cycle wr_en=one-hot(current_layer), wr_x/y/color = tool inputs. Latency is 1 cycle.
  - tool_valid with the active layer invisible → wr_en=0, dropped+1.
  - tool_valid while busy → wr_en carries sweep traffic only, dropped+1.
  - dropped saturates at 255.
- FSM has two states, IDLE and CLEAR.
- IDLE→CLEAR on clear_req:
  - Latch the target layer = current_layer.
  - Reset the sweep counters sx=0, sy=0.
  - busy=1 from the next cycle.
  - Clear proceeds regardless of visibility.
  - clear_req together with tool_valid in the same cycle: the clear wins, the tool write is dropped (dropped+1).
  - clear_req together with layer_toggle in the same cycle: the toggle is applied first, and the clear targets the new layer.
- CLEAR sweep:
  - Each cycle: wr_en=one-hot(target), wr_x=sx, wr_y=sy, wr_color=NONE_INDEX.
  - Order is row-major: sx increments, wraps at WIDTH-1 to 0 and sy increments.
  - Exactly WIDTH*HEIGHT consecutive write cycles.
- CLEAR→IDLE after the write at (WIDTH-1, HEIGHT-1):
  - The following cycle has busy=0, clear_done=1 (one cycle only) and wr_en=0.
  - New requests are accepted from that cycle.
- clear_req while busy is ignored. It does not restart or extend the sweep.
- Reset mid-sweep aborts immediately: wr_en=0 and busy=0. The canvas is left partially cleared, which is acceptable.
- Tool writes cannot interleave with a sweep. wr_en is never multi-hot.
- Counter widths are $clog2(WIDTH) and $clog2(HEIGHT). Wrap is by explicit compare, not overflow, so non-power-of-2 sizes work.

Test Plan (bench params WIDTH=4, HEIGHT=2, NUM_LAYERS=3, COLOR_W=3, NONE_INDEX=0):
- Reset then 4 layer_toggle pulses → current_layer sequence 2,3,1,2. wr_en stays 000.
- current_layer=2, visible=3'b010, tool_valid with (3,1,color 5) → next cycle wr_en=3'b010, wr_x=3, wr_y=1, wr_color=5. Same with visible=3'b000 → wr_en=000, dropped=1.
- clear_req on layer 1 → busy for 8 cycles with wr_en=3'b001, addresses (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1), colour 0. Then clear_done=1 for exactly 1 cycle and busy=0.
- During that sweep: tool_valid ×3, layer_toggle ×1, clear_req ×1 → dropped+3, current_layer unchanged, the sweep is still exactly 8 writes, no second clear.
- clear_req and layer_toggle in the same cycle while on layer 3 → the sweep targets layer 1 (wr_en=3'b001).
- Assert reset at sweep cycle 4 → wr_en=0, busy=0, current_layer=1 immediately. A following clear_req starts again at (0,0).
